spcpu_mem_responder: RTL
========================

Name: spcpu_mem_responder

Overview:
Synthesizable memory-side responder for the spcpu data bus. It answers CPU reads and writes on the shared bidirectional 16-bit bus using the CPU's address, access size and write-enable signals. It adds a post-reset memory-clear sweep and a byte-wide preload port for loading programs. It also provides sticky misalignment fault reporting. It replaces the behavioural bench memory and sits between spcpu and the top level or test bench.

Parameters:
MEM_DEPTH_BYTES, 65536, byte capacity; must be a power of 2 and at least 4.
ADDR_WIDTH, 16, width of data_inout_addr and ld_addr; matches the CPU address width.
CLEAR_ON_RESET, 1, when 1, a zero-fill sweep runs after reset; when 0, the block enters READY immediately.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
data_inout  inout  16  shared data bus; driven by this block only when data_inout_we=0, otherwise high-Z.
data_inout_addr  input  ADDR_WIDTH  CPU byte address.
data_acc_sz  input  1  access size, encoded as pkg_cpu::cpu_data_acc_sz_8 or pkg_cpu::cpu_data_acc_sz_16.
data_inout_we  input  1  1 = CPU write, 0 = CPU read.
ld_valid  input  1  preload byte request.
ld_addr  input  ADDR_WIDTH  preload byte address.
ld_data  input  8  preload byte.
ld_ready  output  1  preload accept; a transfer occurs when ld_valid && ld_ready.
busy  output  1  high while the clear sweep runs; the CPU is held in reset while busy=1.
align_fault  output  1  sticky flag: a 16-bit access was made at an odd address.
fault_addr  output  ADDR_WIDTH  address of the first misaligned access since reset.

Behaviour:
- Storage: byte array mem[0:MEM_DEPTH_BYTES-1]. The effective address is the low log2(MEM_DEPTH_BYTES) bits of the input address; higher bits are ignored.
- Byte order is big-endian. A 16-bit access at address A covers mem[A] -> data[15:8] and mem[A+1] -> data[7:0]. A+1 wraps modulo MEM_DEPTH_BYTES.
- FSM has two states, CLEAR and READY.
- Reset (synchronous, any state, including mid-sweep):
  - state <= CLEAR if CLEAR_ON_RESET=1, else READY.
  - clr_ptr <= 0, align_fault <= 0, fault_addr <= 0.
  - Memory contents are not touched by reset itself.
- CLEAR:
  - Each clock: mem[clr_ptr] <= 0, mem[clr_ptr+1] <= 0, clr_ptr <= clr_ptr+2.
  - When clr_ptr == MEM_DEPTH_BYTES-2, that pair is cleared and state <= READY.
  - busy=1 for exactly MEM_DEPTH_BYTES/2 cycles after the reset cycle.
  - CPU reads return 16'h0000. CPU writes and preloads are ignored. ld_ready=0.
  - align_fault is not updated.
- READY: busy=0.
- Read (data_inout_we=0): combinational, same cycle, so the CPU samples valid data on the next posedge.
  - 16-bit: {mem[A], mem[A+1]}.
  - 8-bit: {8'h00, mem[A]}.
  - The bus is driven continuously while data_inout_we=0, including during reset, where it reads as 16'h0000 if state=CLEAR.
- Write (data_inout_we=1): committed on posedge.
  - 16-bit: mem[A] <= data[15:8], mem[A+1] <= data[7:0].
  - 8-bit: mem[A] <= data[7:0].
  - data_inout is high-Z from this block.
- Preload: ld_ready = (state==READY) && !data_inout_we. On accept, mem[ld_addr] <= ld_data at posedge.
  - CPU writes therefore always win. A preload and a CPU read in the same cycle are both legal; the read sees pre-edge contents.
- Misalignment: a 16-bit access (read or write) in READY with A[0]=1 completes normally, with wrap.
  - The same edge sets align_fault <= 1.
  - fault_addr captures the raw data_inout_addr only if align_fault was 0; later faults do not overwrite it.
  - 8-bit accesses never fault.
- Any pre-edge read sees old data: read-during-write to the same address returns pre-write contents combinationally until the edge.

Test Plan:
1. MEM_DEPTH_BYTES=256, CLEAR_ON_RESET=1. Assert reset for 1 cycle, then release. busy=1 for 128 cycles, then 0. Reads during the sweep return 0000. After the sweep, a read of addr 8'hFE returns 0000.
2. In READY, preload ld_addr 0x10/0x11 with 0xAB/0xCD. A 16-bit read at 0x10 returns ABCD. An 8-bit read at 0x11 returns 00CD.
3. CPU 16-bit write of 1234 at 0x20, then an 8-bit write of 0x56 at 0x21. A 16-bit read at 0x20 returns 1256.
4. Hold ld_valid=1 with data_inout_we=1 on the same cycle. ld_ready=0 and the preload byte is not written. On the next cycle with we=0, ld_ready=1 and the preload is accepted.
5. 16-bit write of BEEF at 0xFF (DEPTH 256). mem[0xFF]=BE, mem[0x00]=EF, align_fault=1, fault_addr=0x00FF. A second misaligned access at 0x31 leaves fault_addr at 0x00FF. Reset clears both.
6. Assert reset at cycle 50 of the sweep. clr_ptr restarts at 0 and busy stays high for a further full 128 cycles. With CLEAR_ON_RESET=0, busy=0 on the cycle after reset and previously written data is retained.

Source files
------------

// File: rtl/spcpu_mem_responder.sv
// Byte-addressed, big-endian memory that answers the spcpu data bus. It adds a post-reset zero-fill
// sweep, a byte preload port and a sticky fault flag for odd 16-bit accesses.
module spcpu_mem_responder #(
    parameter int MEM_DEPTH_BYTES = 65536,
    parameter int ADDR_WIDTH      = 16,
    parameter int CLEAR_ON_RESET  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    inout  wire  [15:0]           data_inout,
    input  logic [ADDR_WIDTH-1:0] data_inout_addr,
    input  logic                  data_acc_sz,
    input  logic                  data_inout_we,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [7:0]            ld_data,
    output logic                  ld_ready,
    output logic                  busy,
    output logic                  align_fault,
    output logic [ADDR_WIDTH-1:0] fault_addr
);

    localparam int AW = $clog2(MEM_DEPTH_BYTES);
    // Size encoding matches pkg_cpu: 0 = 8-bit access, 1 = 16-bit access.
    localparam logic ACC_SZ_16 = 1'b1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_ptr;
    logic [7:0]      r_mem [MEM_DEPTH_BYTES];

    logic [AW-1:0]   w_a;
    logic [AW-1:0]   w_a1;
    logic [AW-1:0]   w_clr_ptr1;
    logic            w_is16;
    logic            w_ready;
    logic            w_ld_fire;
    logic [15:0]     w_rd_dat;

    assign w_a        = data_inout_addr[AW-1:0];
    assign w_a1       = w_a + AW'(1);
    assign w_clr_ptr1 = r_clr_ptr + AW'(1);
    assign w_is16     = (data_acc_sz == ACC_SZ_16);
    assign w_ready    = (r_state == ST_READY);
    assign w_ld_fire  = ld_valid && ld_ready;

    assign busy       = (r_state == ST_CLEAR);
    assign ld_ready   = w_ready && !data_inout_we;

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_CLEAR && r_clr_ptr == AW'(MEM_DEPTH_BYTES - 2)) begin
            w_state_nxt = ST_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_ptr   <= '0;
            align_fault <= 1'b0;
            fault_addr  <= '0;
        end else begin
            if (!w_ready) begin
                r_clr_ptr <= r_clr_ptr + AW'(2);
            end
            // Only the first odd 16-bit access is recorded; the flag stays up until reset.
            if (w_ready && w_is16 && w_a[0]) begin
                align_fault <= 1'b1;
                if (!align_fault) begin
                    fault_addr <= data_inout_addr;
                end
            end
        end
    end

    // Storage has no reset; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (!w_ready) begin
            r_mem[r_clr_ptr]  <= 8'h00;
            r_mem[w_clr_ptr1] <= 8'h00;
        end else if (data_inout_we) begin
            if (w_is16) begin
                r_mem[w_a]  <= data_inout[15:8];
                r_mem[w_a1] <= data_inout[7:0];
            end else begin
                r_mem[w_a]  <= data_inout[7:0];
            end
        end else if (w_ld_fire) begin
            r_mem[ld_addr[AW-1:0]] <= ld_data;
        end
    end

    always_comb begin
        w_rd_dat = 16'h0000;
        if (w_ready) begin
            if (w_is16) begin
                w_rd_dat = {r_mem[w_a], r_mem[w_a1]};
            end else begin
                w_rd_dat = {8'h00, r_mem[w_a]};
            end
        end
    end

    assign data_inout = data_inout_we ? 16'hzzzz : w_rd_dat;

endmodule
